// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns single-beat register commands into AW/W/B or AR/R transactions.
// One transaction in flight; completion reported as a one-cycle rsp_done pulse.
module axi4_lite_master #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [1:0]        RRESP
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e state_q;
  logic   aw_done, w_done, b_done, ar_done, r_done;
  logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic   wr_fin, rd_fin;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  // Handshakes completing this cycle count towards the exit condition.
  assign wr_fin = (aw_done | aw_hs) & (w_done | w_hs) & (b_done | b_hs);
  assign rd_fin = (ar_done | ar_hs) & (r_done | r_hs);

  assign cmd_ready = (state_q == StIdle);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= StIdle;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_done  <= 1'b0;
      AWADDR    <= '0;
      ARADDR    <= '0;
      WDATA     <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      b_done    <= 1'b0;
      ar_done   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      rsp_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            AWADDR <= cmd_addr;
            ARADDR <= cmd_addr;
            WDATA  <= cmd_wdata;
            if (cmd_write) begin
              state_q <= StWrite;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              BREADY  <= 1'b1;
            end else begin
              state_q <= StRead;
              ARVALID <= 1'b1;
              RREADY  <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (aw_hs) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          // An early B response is kept; the pending AW/W channel keeps driving.
          if (b_hs && !b_done) begin
            rsp_resp <= BRESP;
            b_done   <= 1'b1;
          end
          if (wr_fin) begin
            BREADY   <= 1'b0;
            rsp_done <= 1'b1;
            state_q  <= StDone;
          end
        end
        StRead: begin
          if (ar_hs) begin
            ARVALID <= 1'b0;
            ar_done <= 1'b1;
          end
          if (r_hs) begin
            RREADY    <= 1'b0;
            r_done    <= 1'b1;
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
          end
          if (rd_fin) begin
            rsp_done <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          b_done  <= 1'b0;
          ar_done <= 1'b0;
          r_done  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: configurable stub slave, transaction-level model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_axi4_lite_master;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_done;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic              ARVALID, ARREADY, RVALID, RREADY;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic [1:0]        BRESP, RRESP;

  axi4_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP)
  );

  always #5 ACLK = ~ACLK;

  int unsigned cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stub slave: 4 registers decoded on address bits [3:2] ----------------
  int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0, b_lat = 0;
  bit          r_same = 1'b0, b_early = 1'b0, junk_en = 1'b0, rand_resp = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] smem [4];
  bit          s_aw, s_w, s_wrote, s_b_sched, s_b_pend, s_b_done, s_r_pend, s_rv;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic [3:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;

  task automatic slave_clear();
    for (int i = 0; i < 4; i++) smem[i] = '0;
    {s_aw, s_w, s_wrote, s_b_sched, s_b_pend, s_b_done, s_r_pend, s_rv} = '0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
    BRESP = 0; RRESP = 0; RDATA = 0;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge ACLK);
      if (AWVALID && AWREADY) begin s_aw = 1; s_awaddr = AWADDR; aw_cnt = 0; end
      else if (AWVALID) aw_cnt++;
      if (WVALID && WREADY) begin s_w = 1; s_wdata = WDATA; w_cnt = 0; end
      else if (WVALID) w_cnt++;
      if (ARVALID && ARREADY) begin
        s_araddr = ARADDR; ar_cnt = 0;
        if (!RVALID) begin s_r_pend = 1; r_cnt = r_lat; end
      end else if (ARVALID) ar_cnt++;
      if (RVALID && RREADY) s_rv = 0;
      if (BVALID && BREADY) s_b_done = 1;
      if (s_aw && s_w && !s_wrote) begin smem[s_awaddr[3:2]] = s_wdata; s_wrote = 1; end
      if (!s_b_sched && (b_early ? (s_aw || s_w) : (s_aw && s_w))) begin
        s_b_sched = 1; s_b_pend = 1; b_cnt = b_lat;
      end
      if (s_wrote && s_b_done) {s_aw, s_w, s_wrote, s_b_sched, s_b_done} = '0;

      @(posedge ACLK);
      #1;
      if (!ARESETn) begin
        slave_clear();
      end else begin
        AWREADY = AWVALID ? (aw_cnt >= aw_lat) : (junk_en && $urandom_range(1) == 1);
        WREADY  = WVALID  ? (w_cnt >= w_lat)   : (junk_en && $urandom_range(1) == 1);
        ARREADY = ARVALID ? (ar_cnt >= ar_lat) : (junk_en && $urandom_range(1) == 1);
        BVALID = 0;
        if (s_b_pend) begin
          if (b_cnt == 0) begin
            BVALID = 1; s_b_pend = 0;
            BRESP = rand_resp ? 2'($urandom_range(3)) : bresp_cfg;
          end else b_cnt--;
        end
        if (!s_rv) begin
          if (s_r_pend) begin
            if (r_cnt == 0) begin
              s_rv = 1; s_r_pend = 0; RDATA = smem[s_araddr[3:2]];
              RRESP = rand_resp ? 2'($urandom_range(3)) : 2'b00;
            end else r_cnt--;
          end else if (r_same && ARVALID && ARREADY) begin
            s_rv = 1; RDATA = smem[ARADDR[3:2]];
            RRESP = rand_resp ? 2'($urandom_range(3)) : 2'b00;
          end
        end
        RVALID = s_rv;
      end
    end
  end

  // ---------------- transaction-level model and per-cycle compare ----------------
  bit          m_busy, m_wr, m_aw, m_w, m_b, m_ar, m_r, m_fin;
  logic [3:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [1:0]  m_resp;
  logic [31:0] ref_mem [4];
  logic [31:0] exp_rd [$];

  initial begin
    {m_busy, m_wr, m_aw, m_w, m_b, m_ar, m_r, m_fin} = '0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_resp = 0;
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    forever begin
      bit e_aw, e_w, e_br, e_ar, e_rr;
      logic [31:0] want;
      @(negedge ACLK);
      e_aw = m_busy && m_wr && !m_aw && !m_fin;
      e_w  = m_busy && m_wr && !m_w && !m_fin;
      e_br = m_busy && m_wr && !m_fin;
      e_ar = m_busy && !m_wr && !m_ar && !m_fin;
      e_rr = m_busy && !m_wr && !m_r && !m_fin;
      if (rsp_done === 1'b1) done_cnt++;
      if (chk_en) begin
        chk("cmd_ready", cmd_ready, !m_busy);
        chk("AWVALID", AWVALID, e_aw);
        chk("WVALID", WVALID, e_w);
        chk("BREADY", BREADY, e_br);
        chk("ARVALID", ARVALID, e_ar);
        chk("RREADY", RREADY, e_rr);
        chk("AWADDR", AWADDR, m_addr);
        chk("ARADDR", ARADDR, m_addr);
        chk("WDATA", WDATA, m_wdata);
        chk("rsp_done", rsp_done, m_fin);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_resp", rsp_resp, m_resp);
        if (m_fin && !m_wr) begin
          want = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hxxxx_xxxx;
          chk("read_scoreboard", rsp_rdata, want);
        end
      end
      if (!ARESETn) begin
        {m_busy, m_wr, m_aw, m_w, m_b, m_ar, m_r, m_fin} = '0;
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_resp = 0;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        exp_rd.delete();
      end else if (m_fin) begin
        m_busy = 0; m_fin = 0;
      end else if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1; m_wr = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
          {m_aw, m_w, m_b, m_ar, m_r} = '0;
          if (!cmd_write) exp_rd.push_back(ref_mem[cmd_addr[3:2]]);
        end
      end else if (m_wr) begin
        if (e_aw && AWREADY) m_aw = 1;
        if (e_w && WREADY) m_w = 1;
        if (e_br && BVALID && !m_b) begin m_b = 1; m_resp = BRESP; end
        if (m_aw && m_w && m_b) begin m_fin = 1; ref_mem[m_addr[3:2]] = m_wdata; end
      end else begin
        if (e_ar && ARREADY) m_ar = 1;
        if (e_rr && RVALID) begin m_r = 1; m_rdata = RDATA; m_resp = RRESP; end
        if (m_ar && m_r) m_fin = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called in the drive slot (just after a rising edge); returns in the same slot.
  task automatic issue(input bit w, input logic [3:0] a, input logic [31:0] d, input bit keep,
                       output int acc);
    int n;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    @(negedge ACLK);
    while (!cmd_ready && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    chk("accept_in_time", (n < 200), 1);
    acc = cyc;
    @(posedge ACLK);
    #2;
    if (!keep) cmd_valid = 0;
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    @(negedge ACLK);
    while (rsp_done !== 1'b1 && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    chk("done_in_time", (n < 200), 1);
    dc = cyc;
    @(posedge ACLK);
    #2;
  endtask

  initial begin
    int acc, dc, d0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    ARESETn = 0;
    @(posedge ACLK); #2;
    chk_en = 1;
    @(negedge ACLK);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_done}, 0);
    chk("reset_regs", {AWADDR, WDATA[27:0]} | rsp_rdata | rsp_resp, 0);
    @(posedge ACLK); #2;
    ARESETn = 1;

    // Zero-wait write then read-back with R in the same cycle as AR.
    issue(1, 4'h4, 32'hDEADBEEF, 0, acc);
    wait_done(dc);
    chk("write_latency", dc - acc, 3);
    chk("write_resp", rsp_resp, 2'b00);
    r_same = 1;
    issue(0, 4'h4, 32'h0, 0, acc);
    wait_done(dc);
    chk("read_latency", dc - acc, 2);
    chk("read_data", rsp_rdata, 32'hDEADBEEF);
    r_same = 0;

    // Skewed write: AWREADY in cycle 1, WREADY in cycle 4.
    aw_lat = 0; w_lat = 3;
    issue(1, 4'h8, 32'h12345678, 0, acc);
    @(negedge ACLK);
    chk("skew_c1_valids", {AWVALID, WVALID}, 2'b11);
    @(negedge ACLK);
    chk("skew_c2_valids", {AWVALID, WVALID}, 2'b01);
    wait_done(dc);
    chk("skew_latency", dc - acc, 6);
    w_lat = 0;

    // Back-to-back with cmd_valid held high throughout.
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) issue(1, 4'(i * 4), 32'h11111111 * (i + 1), 1, acc);
    for (int i = 0; i < 4; i++) issue(0, 4'(i * 4), 32'h0, (i != 3), acc);
    wait_done(dc);
    chk("b2b_completions", done_cnt - d0, 8);
    chk("b2b_last_read", rsp_rdata, 32'h44444444);

    // Busy-time command ignored, then error write response.
    aw_lat = 2; bresp_cfg = 2'b10;
    issue(1, 4'hC, 32'hCAFEF00D, 0, acc);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h0; cmd_wdata = 32'hBAD0BAD0;
    @(posedge ACLK); #2;
    cmd_valid = 0;
    wait_done(dc);
    chk("err_resp", rsp_resp, 2'b10);
    chk("err_rdata_kept", rsp_rdata, 32'h44444444);
    chk("busy_cmd_not_latched", AWADDR, 4'hC);
    bresp_cfg = 2'b00; aw_lat = 0;

    // Reset while AWVALID is high.
    aw_lat = 8; w_lat = 8;
    d0 = done_cnt;
    issue(1, 4'h4, 32'h55AA55AA, 0, acc);
    ARESETn = 0;
    @(negedge ACLK);
    chk("pre_reset_awvalid", AWVALID, 1);
    @(negedge ACLK);
    chk("reset_mid_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_done}, 0);
    chk("reset_mid_ready", cmd_ready, 1);
    @(posedge ACLK); #2;
    ARESETn = 1;
    repeat (4) @(negedge ACLK);
    chk("reset_no_done", done_cnt - d0, 0);
    @(posedge ACLK); #2;
    aw_lat = 0; w_lat = 0;

    // Randomized traffic against the model.
    junk_en = 1; rand_resp = 1;
    for (int t = 0; t < 300; t++) begin
      aw_lat = $urandom_range(3); w_lat = $urandom_range(3); b_lat = $urandom_range(2);
      ar_lat = $urandom_range(3); r_lat = $urandom_range(2);
      r_same = ($urandom_range(1) == 1); b_early = ($urandom_range(3) == 0);
      repeat ($urandom_range(2)) begin @(posedge ACLK); #2; end
      issue($urandom_range(1) == 1, 4'($urandom_range(15)), $urandom, 0, acc);
      if ($urandom_range(3) == 0) begin
        cmd_valid = 1; cmd_write = ($urandom_range(1) == 1);
        cmd_addr = 4'($urandom_range(15)); cmd_wdata = $urandom;
        @(posedge ACLK); #2;
        cmd_valid = 0;
      end
      wait_done(dc);
    end

    repeat (3) @(negedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
